// File: rtl/match_window_counter.sv
// Counts detector match pulses over back-to-back programmable windows and
// publishes each window's count and threshold alarm through a one-entry valid/ready slot.
module match_window_counter #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             z,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_alarm,
  output logic             res_lost
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state_q;
  logic [WIN_W-1:0] rem_q;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             res_valid_q;
  logic [CNT_W-1:0] res_count_q;
  logic             res_alarm_q;
  logic             res_lost_q;

  logic [WIN_W-1:0] rem_d;
  logic [CNT_W-1:0] cnt_d;
  logic             xfer;
  logic             win_end;

  // A zero window length behaves as a one-cycle window.
  assign rem_d   = (win_len == '0) ? WIN_ONE : win_len;
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(z);
  assign xfer    = res_valid_q & res_ready;
  assign win_end = (state_q == COUNT) & en & (rem_q == WIN_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      thr_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_alarm_q <= 1'b0;
      res_lost_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (en) begin
          state_q <= COUNT;
          rem_q   <= rem_d;
          thr_q   <= threshold;
          cnt_q   <= '0;
        end
      end else begin
        if (!en) begin
          state_q <= IDLE;
          rem_q   <= '0;
          cnt_q   <= '0;
        end else if (win_end) begin
          // Next window starts on the same edge, so no cycle goes uncounted.
          rem_q <= rem_d;
          thr_q <= threshold;
          cnt_q <= '0;
        end else begin
          rem_q <= rem_q - WIN_ONE;
          cnt_q <= cnt_d;
        end
      end

      if (win_end && (!res_valid_q || xfer)) begin
        res_valid_q <= 1'b1;
        res_count_q <= cnt_d;
        res_alarm_q <= (cnt_d >= thr_q);
      end else if (xfer) begin
        res_valid_q <= 1'b0;
      end

      // A transfer always frees the slot, so it can never coincide with a drop.
      if (xfer) begin
        res_lost_q <= 1'b0;
      end else if (win_end && res_valid_q) begin
        res_lost_q <= 1'b1;
      end
    end
  end

  assign busy      = (state_q == COUNT);
  assign res_valid = res_valid_q;
  assign res_count = res_count_q;
  assign res_alarm = res_alarm_q;
  assign res_lost  = res_lost_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Scoreboard bench for match_window_counter: expected results are queued as stimulus is
// driven and compared against results captured on each handshake transfer.
module tb_match_window_counter;

  localparam int WIN_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             z;
  logic             en;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] threshold;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_alarm;
  logic             res_lost;

  // Wider-window instance used only to reach real counter saturation.
  logic             en2;
  logic [8:0]       win_len2;
  logic             busy2;
  logic             res_valid2;
  logic [CNT_W-1:0] res_count2;
  logic             res_alarm2;
  logic             res_lost2;

  typedef logic [CNT_W:0] res_t;
  res_t exp_q[$];
  res_t got_q[$];
  res_t g, e;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  match_window_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .z(z), .en(en), .win_len(win_len),
    .threshold(threshold), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_alarm(res_alarm),
    .res_lost(res_lost)
  );

  match_window_counter #(.WIN_W(9), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .reset_n(reset_n), .z(z), .en(en2), .win_len(win_len2),
    .threshold(threshold), .busy(busy2), .res_valid(res_valid2),
    .res_ready(res_ready), .res_count(res_count2), .res_alarm(res_alarm2),
    .res_lost(res_lost2)
  );

  // One clock: capture a result if it transfers on the coming edge, then land after negedge.
  task automatic tick();
    if (res_valid === 1'b1 && res_ready === 1'b1) got_q.push_back({res_count, res_alarm});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; z = 1'b1; win_len = '0; threshold = '0; res_ready = 1'b0;
    en2 = 1'b0; win_len2 = '0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({busy, res_valid, res_count, res_alarm, res_lost} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero", {busy, res_valid, res_count, res_alarm, res_lost});
    end
    reset_n = 1'b1; en = 1'b1; win_len = 8'd10; threshold = 8'd1;
    repeat (5) tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy_before: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, res_valid, res_count, res_alarm, res_lost} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got %b expected all zero", {busy, res_valid, res_count, res_alarm, res_lost});
    end
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if ({busy, res_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle_after: busy,valid got %b expected 00", {busy, res_valid});
    end
    got_q.delete();
  endtask

  task automatic test_basic();
    win_len = 8'd8; threshold = 8'd2; res_ready = 1'b1; z = 1'b1; en = 1'b1;
    exp_q.push_back({8'd3, 1'b1});
    tick();
    for (int c = 1; c <= 8; c++) begin
      z = (c == 2 || c == 5 || c == 8);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy c%0d: got %b expected 1", c, busy); end
      tick();
      if (c == 7) begin
        n_cmp++;
        if (res_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b expected 0", res_valid); end
      end
    end
    n_cmp++;
    if ({res_valid, res_count, res_alarm} !== {1'b1, 8'd3, 1'b1}) begin
      n_err++; $display("FAIL basic_result: got %b expected %b", {res_valid, res_count, res_alarm}, {1'b1, 8'd3, 1'b1});
    end
    en = 1'b0; z = 1'b0;
    tick();
    n_cmp++;
    if ({busy, res_valid} !== 2'b00) begin n_err++; $display("FAIL basic_after: busy,valid got %b expected 00", {busy, res_valid}); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_n_results: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL basic_sb: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    win_len = 8'd4; threshold = 8'd5; res_ready = 1'b1; z = 1'b0; en = 1'b1;
    repeat (3) exp_q.push_back({8'd4, 1'b0});
    tick();
    z = 1'b1;
    repeat (12) tick();
    en = 1'b0; z = 1'b0;
    tick();
    n_cmp++;
    if ({res_valid, res_lost} !== 2'b00) begin n_err++; $display("FAIL b2b_flags: valid,lost got %b expected 00", {res_valid, res_lost}); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_n_results: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL b2b_sb: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_drop();
    res_t pat1 = 3'b101;
    res_ready = 1'b0; win_len = 8'd3; threshold = 8'd1; z = 1'b0; en = 1'b1;
    exp_q.push_back({8'd2, 1'b1});
    tick();
    for (int c = 0; c < 3; c++) begin z = pat1[c]; tick(); end
    n_cmp++;
    if ({res_valid, res_lost} !== 2'b10) begin n_err++; $display("FAIL drop_first: valid,lost got %b expected 10", {res_valid, res_lost}); end
    z = 1'b1;
    repeat (3) tick();
    en = 1'b0; z = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({res_valid, res_count, res_alarm, res_lost} !== {1'b1, 8'd2, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL drop_held: got %b expected %b", {res_valid, res_count, res_alarm, res_lost}, {1'b1, 8'd2, 1'b1, 1'b1});
    end
    // New window ends on the same edge the held result transfers.
    en = 1'b1; win_len = 8'd2; threshold = 8'd3;
    exp_q.push_back({8'd2, 1'b0});
    tick();
    threshold = 8'd0; win_len = 8'd7; z = 1'b1;
    tick();
    res_ready = 1'b1;
    tick();
    n_cmp++;
    if ({res_valid, res_count, res_alarm, res_lost} !== {1'b1, 8'd2, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL drop_coincide: got %b expected %b", {res_valid, res_count, res_alarm, res_lost}, {1'b1, 8'd2, 1'b0, 1'b0});
    end
    en = 1'b0; z = 1'b0;
    tick();
    n_cmp++;
    if ({res_valid, res_count, res_lost} !== {1'b0, 8'd2, 1'b0}) begin
      n_err++; $display("FAIL drop_release: got %b expected %b", {res_valid, res_count, res_lost}, {1'b0, 8'd2, 1'b0});
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL drop_n_results: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL drop_sb: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    res_t zpat = 3'b101;
    res_ready = 1'b1; win_len = 8'd5; threshold = 8'd1; z = 1'b0; en = 1'b1;
    tick();
    z = 1'b1;
    repeat (2) tick();
    en = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    repeat (6) tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b expected 0", res_valid); end
    // Zero window length gives one-cycle windows.
    win_len = 8'd0; z = 1'b0; en = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      z = zpat[c];
      exp_q.push_back({7'd0, zpat[c], zpat[c]});
      tick();
      n_cmp++;
      if ({res_valid, res_count} !== {1'b1, 7'd0, zpat[c]}) begin
        n_err++; $display("FAIL win0_result c%0d: got %b expected %b", c, {res_valid, res_count}, {1'b1, 7'd0, zpat[c]});
      end
    end
    en = 1'b0; z = 1'b0;
    tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL abort_n_results: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL abort_sb: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    res_ready = 1'b1; win_len = 8'd255; threshold = 8'd255; z = 1'b1; en = 1'b1;
    exp_q.push_back({8'd255, 1'b1});
    tick();
    repeat (255) tick();
    n_cmp++;
    if ({res_valid, res_count} !== {1'b1, 8'd255}) begin
      n_err++; $display("FAIL sat255_result: got %b expected %b", {res_valid, res_count}, {1'b1, 8'd255});
    end
    en = 1'b0;
    tick();
    threshold = 8'd0; z = 1'b0; win_len = 8'd3; en = 1'b1;
    exp_q.push_back({8'd0, 1'b1});
    tick();
    repeat (3) tick();
    en = 1'b0;
    tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL sat_n_results: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL sat_sb: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    // 300 matches in a 300-cycle window must stop at the counter maximum.
    threshold = 8'd200; z = 1'b1; win_len2 = 9'd300; en2 = 1'b1;
    tick();
    repeat (300) tick();
    n_cmp++;
    if ({res_valid2, res_count2, res_alarm2} !== {1'b1, 8'd255, 1'b1}) begin
      n_err++; $display("FAIL sat300_result: got %b expected %b", {res_valid2, res_count2, res_alarm2}, {1'b1, 8'd255, 1'b1});
    end
    en2 = 1'b0; z = 1'b0;
    tick();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_abort();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
